if_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory. Holds the program counter, drives the fetch address to instruction memory, and captures the returned word into the IF/ID pipeline register. Handles hazard-unit freeze and branch/jump redirect with bubble insertion. Downstream decode consumes the IF/ID outputs.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/pc_reg.sv | 34 +++
 rtl/if_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: widths, NOP encoding,
// the IF/ID payload struct and PC alignment helper.
package if_stage_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc_plus4;
        logic              valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};

    // Every PC load is word-aligned, whatever the source.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Word-aligned program counter with async active-high reset and load enable.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [PC_W-1:0] next_pc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = align_pc(next_pc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch address, IF/ID register, freeze and redirect.
// Optional fetched-instruction counter enabled by defining IF_FETCH_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_addr,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc_plus4,
`ifdef IF_FETCH_CNT_EN
    output logic [31:0]       fetch_cnt,
`endif
    output logic              if_id_valid
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4_c;
    logic [PC_W-1:0] next_pc_c;
    logic            pc_load_c;
    logic            fetch_c;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // Redirect overrides freeze; otherwise the PC advances only when not frozen.
    assign pc_plus4_c = pc + PC_W'(PC_STEP);
    assign next_pc_c  = br_taken ? br_addr : pc_plus4_c;
    assign pc_load_c  = br_taken | ~freeze;
    assign fetch_c    = ~br_taken & ~freeze;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load_c),
        .next_pc (next_pc_c),
        .pc      (pc)
    );

    assign imem_addr = pc;

    always_comb begin
        if_id_d = if_id_q;
        if (br_taken) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (!freeze) begin
            if_id_d.inst     = imem_data;
            if_id_d.pc_plus4 = pc_plus4_c;
            if_id_d.valid    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_inst     = if_id_q.inst;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_valid    = if_id_q.valid;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_d;
    logic [31:0] fetch_cnt_q;

    // Counts only edges that load a real instruction into IF/ID.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (fetch_c) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    logic unused_fetch;
    assign unused_fetch = fetch_c;
`endif

endmodule
